// File: rtl/glb_arb_pkg.sv
// Shared types and sizing for the GLB port arbiter.
// Command stage structs are sized from these constants.
package glb_arb_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BE_W      = 4;

  typedef struct packed {
    logic [BE_W-1:0]   re;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } rd_cmd_t;

  typedef struct packed {
    logic [BE_W-1:0]      we;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_SIZE-1:0] data;
  } wr_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest valid index at or above ptr, wrapping.
// The GLB never stalls, so a grant is always an acceptance and advances ptr.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    o_ready,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_grant
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_d;
  logic            w_any;
  logic [ID_W-1:0] w_gid;

  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    // First pass covers ptr..N-1, second pass wraps through 0..ptr-1.
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_any && i_valid[i] && (ID_W'(i) >= r_ptr)) begin
        w_any = 1'b1;
        w_gid = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_any && i_valid[i]) begin
        w_any = 1'b1;
        w_gid = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    if (w_any) begin
      w_ptr_d = (w_gid == ID_W'(N - 1)) ? '0 : w_gid + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

  assign o_ready    = w_any ? (N'(1) << w_gid) : '0;
  assign o_grant_id = w_gid;
  assign o_grant    = w_any;

endmodule

// File: rtl/glb_port_arbiter.sv
// Shares the GLB read and write ports between requesters with independent
// round-robin arbiters, a one-cycle command stage and a read-id return pipeline.
module glb_port_arbiter
  import glb_arb_pkg::*;
#(
  // Command structs are sized by glb_arb_pkg; change sizes there, not here.
  parameter int unsigned P_NUM_REQ   = NUM_REQ,
  parameter int unsigned P_DATA_SIZE = DATA_SIZE,
  parameter int unsigned P_ADDR_W    = ADDR_W,
  parameter int unsigned P_ID_W      = ID_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_NUM_REQ-1:0]             i_rd_valid,
  output logic [P_NUM_REQ-1:0]             o_rd_ready,
  input  logic [P_NUM_REQ*4-1:0]           i_rd_re,
  input  logic [P_NUM_REQ*P_ADDR_W-1:0]    i_rd_addr,
  output logic [P_NUM_REQ-1:0]             o_rsp_valid,
  output logic [P_DATA_SIZE-1:0]           o_rsp_data,
  input  logic [P_NUM_REQ-1:0]             i_wr_valid,
  output logic [P_NUM_REQ-1:0]             o_wr_ready,
  input  logic [P_NUM_REQ*4-1:0]           i_wr_we,
  input  logic [P_NUM_REQ*P_ADDR_W-1:0]    i_wr_addr,
  input  logic [P_NUM_REQ*P_DATA_SIZE-1:0] i_wr_data,
  output logic [3:0]                       o_glb_re,
  output logic [P_ADDR_W-1:0]              o_glb_r_addr,
  input  logic [P_DATA_SIZE-1:0]           i_glb_r_data,
  output logic [3:0]                       o_glb_we,
  output logic [P_ADDR_W-1:0]              o_glb_w_addr,
  output logic [P_DATA_SIZE-1:0]           o_glb_w_data
);

  logic [P_ID_W-1:0] w_rd_id;
  logic              w_rd_go;
  logic [P_ID_W-1:0] w_wr_id;
  logic              w_wr_go;

  rd_cmd_t           r_rd_cmd;
  logic              r_rd_v1;
  logic              r_rd_v2;
  logic [P_ID_W-1:0] r_rd_id2;
  wr_cmd_t           r_wr_cmd;

  rr_arbiter #(
    .N    (P_NUM_REQ),
    .ID_W (P_ID_W)
  ) u_rd_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_rd_valid),
    .o_ready    (o_rd_ready),
    .o_grant_id (w_rd_id),
    .o_grant    (w_rd_go)
  );

  rr_arbiter #(
    .N    (P_NUM_REQ),
    .ID_W (P_ID_W)
  ) u_wr_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_wr_valid),
    .o_ready    (o_wr_ready),
    .o_grant_id (w_wr_id),
    .o_grant    (w_wr_go)
  );

  // Idle cycles clear the byte enables but keep address/data to avoid toggling.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_cmd <= '0;
      r_rd_v1  <= 1'b0;
      r_rd_v2  <= 1'b0;
      r_rd_id2 <= '0;
    end else begin
      if (w_rd_go) begin
        r_rd_cmd.re   <= i_rd_re[int'(w_rd_id)*4 +: 4];
        r_rd_cmd.addr <= i_rd_addr[int'(w_rd_id)*P_ADDR_W +: P_ADDR_W];
        r_rd_cmd.id   <= w_rd_id;
      end else begin
        r_rd_cmd.re <= '0;
      end
      // Valid travels separately from re so zero-enable reads still respond.
      r_rd_v1  <= w_rd_go;
      r_rd_v2  <= r_rd_v1;
      r_rd_id2 <= r_rd_cmd.id;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_cmd <= '0;
    end else if (w_wr_go) begin
      r_wr_cmd.we   <= i_wr_we[int'(w_wr_id)*4 +: 4];
      r_wr_cmd.addr <= i_wr_addr[int'(w_wr_id)*P_ADDR_W +: P_ADDR_W];
      r_wr_cmd.data <= i_wr_data[int'(w_wr_id)*P_DATA_SIZE +: P_DATA_SIZE];
    end else begin
      r_wr_cmd.we <= '0;
    end
  end

  assign o_glb_re     = r_rd_cmd.re;
  assign o_glb_r_addr = r_rd_cmd.addr;
  assign o_glb_we     = r_wr_cmd.we;
  assign o_glb_w_addr = r_wr_cmd.addr;
  assign o_glb_w_data = r_wr_cmd.data;

  assign o_rsp_valid = r_rd_v2 ? (P_NUM_REQ'(1) << r_rd_id2) : '0;
  assign o_rsp_data  = i_glb_r_data;

endmodule
